// File: rtl/rv32i_pipeline_hazard_ctrl_if.sv
// Control bundle between the RV32i datapath and the hazard/sequencing controller.
// master = datapath side, slave = controller side.
interface rv32i_pipeline_hazard_ctrl_if;
  logic [31:0] instruction_i;
  logic        alu_zero_i;
  logic        alu_lt_i;
  logic        imem_valid_i;
  logic        stall_o;
  logic        pip_jump_o;
  logic        branch_taken_o;
  logic [2:0]  pc_next_sel_o;
  logic [4:0]  rd_add_o;
  logic        reg_we_o;
  logic [1:0]  wb_sel_o;

  modport master (
    output instruction_i,
    output alu_zero_i,
    output alu_lt_i,
    output imem_valid_i,
    input  stall_o,
    input  pip_jump_o,
    input  branch_taken_o,
    input  pc_next_sel_o,
    input  rd_add_o,
    input  reg_we_o,
    input  wb_sel_o
  );

  modport slave (
    input  instruction_i,
    input  alu_zero_i,
    input  alu_lt_i,
    input  imem_valid_i,
    output stall_o,
    output pip_jump_o,
    output branch_taken_o,
    output pc_next_sel_o,
    output rd_add_o,
    output reg_we_o,
    output wb_sel_o
  );
endinterface

// File: rtl/rv32i_pipeline_hazard_ctrl.sv
// RV32i sequencing control: EX/MEM/WB writer scoreboard, RAW stall,
// jump/branch flush, PC select and write-back controls (no forwarding).
package RV32i_pkg;
  localparam logic [2:0] SEL_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] SEL_PC_JAL    = 3'd1;
  localparam logic [2:0] SEL_PC_JALR   = 3'd2;
  localparam logic [2:0] SEL_PC_BRANCH = 3'd3;

  localparam logic [1:0] SEL_WB_ALU       = 2'd0;
  localparam logic [1:0] SEL_WB_MEM       = 2'd1;
  localparam logic [1:0] SEL_WB_PC_PLUS_4 = 2'd2;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [1:0] wb_sel;
  } wb_slot_t;

  typedef struct packed {
    wb_slot_t   wb;
    logic       is_br;
    logic [2:0] func3;
  } ex_slot_t;
endpackage

module rv32i_pipeline_hazard_ctrl
  import RV32i_pkg::*;
(
  input logic clk_i,
  input logic resetn_i,
  rv32i_pipeline_hazard_ctrl_if.slave ctl
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  ex_slot_t ex_q;
  wb_slot_t mem_q;
  wb_slot_t wb_q;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] func3;
  logic       unused_bits;

  assign opcode      = ctl.instruction_i[6:0];
  assign rd          = ctl.instruction_i[11:7];
  assign func3       = ctl.instruction_i[14:12];
  assign rs1         = ctl.instruction_i[19:15];
  assign rs2         = ctl.instruction_i[24:20];
  assign unused_bits = ^ctl.instruction_i[31:25];

  logic op_lui;
  logic op_auipc;
  logic op_jal;
  logic op_jalr;
  logic op_imm;
  logic op_reg;
  logic op_load;
  logic op_store;
  logic op_branch;

  assign op_lui    = (opcode == OP_LUI);
  assign op_auipc  = (opcode == OP_AUIPC);
  assign op_jal    = (opcode == OP_JAL);
  assign op_jalr   = (opcode == OP_JALR);
  assign op_imm    = (opcode == OP_IMM);
  assign op_reg    = (opcode == OP_REG);
  assign op_load   = (opcode == OP_LOAD);
  assign op_store  = (opcode == OP_STORE);
  assign op_branch = (opcode == OP_BRANCH);

  logic       dec_writer;
  logic       dec_use1;
  logic       dec_use2;
  logic [1:0] dec_wb_sel;
  logic       dec_we;

  always_comb begin
    dec_writer = 1'b0;
    dec_use1   = 1'b0;
    dec_use2   = 1'b0;
    dec_wb_sel = SEL_WB_ALU;
    unique case (1'b1)
      op_lui, op_auipc: begin
        dec_writer = 1'b1;
      end
      op_jal: begin
        dec_writer = 1'b1;
        dec_wb_sel = SEL_WB_PC_PLUS_4;
      end
      op_jalr: begin
        dec_writer = 1'b1;
        dec_use1   = 1'b1;
        dec_wb_sel = SEL_WB_PC_PLUS_4;
      end
      op_imm: begin
        dec_writer = 1'b1;
        dec_use1   = 1'b1;
      end
      op_reg: begin
        dec_writer = 1'b1;
        dec_use1   = 1'b1;
        dec_use2   = 1'b1;
      end
      op_load: begin
        dec_writer = 1'b1;
        dec_use1   = 1'b1;
        dec_wb_sel = SEL_WB_MEM;
      end
      op_store, op_branch: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
      end
      default: begin
        dec_writer = 1'b0;
      end
    endcase
  end

  assign dec_we = dec_writer & (rd != 5'd0);

  // x0 sources are filtered here so a writer field never matches them
  logic chk1;
  logic chk2;
  assign chk1 = dec_use1 & (rs1 != 5'd0);
  assign chk2 = dec_use2 & (rs2 != 5'd0);

  function automatic logic hit(wb_slot_t s, logic [4:0] r);
    return s.we & (s.rd == r);
  endfunction

  logic haz1;
  logic haz2;
  logic haz;

  assign haz1 = chk1 & (hit(ex_q.wb, rs1) | hit(mem_q, rs1) | hit(wb_q, rs1));
  assign haz2 = chk2 & (hit(ex_q.wb, rs2) | hit(mem_q, rs2) | hit(wb_q, rs2));
  assign haz  = haz1 | haz2;

  logic cond;
  logic take;

  always_comb begin
    cond = 1'b0;
    case (ex_q.func3)
      3'b000:  cond = ctl.alu_zero_i;
      3'b001:  cond = ~ctl.alu_zero_i;
      3'b100:  cond = ctl.alu_lt_i;
      3'b101:  cond = ~ctl.alu_lt_i;
      3'b110:  cond = ctl.alu_lt_i;
      3'b111:  cond = ~ctl.alu_lt_i;
      default: cond = 1'b0;
    endcase
  end

  assign take = ex_q.is_br & cond;

  logic       stall;
  logic       jump;
  logic [2:0] pc_sel;

  // Taken branch outranks the stall: the stalled DEC instruction is killed anyway
  always_comb begin
    stall  = 1'b0;
    jump   = 1'b0;
    pc_sel = SEL_PC_PLUS_4;
    if (take) begin
      pc_sel = SEL_PC_BRANCH;
    end else if (haz) begin
      stall = 1'b1;
    end else if (op_jal) begin
      jump   = 1'b1;
      pc_sel = SEL_PC_JAL;
    end else if (op_jalr) begin
      jump   = 1'b1;
      pc_sel = SEL_PC_JALR;
    end
  end

  ex_slot_t ex_d;

  always_comb begin
    ex_d = '0;
    if (!(take | stall)) begin
      ex_d.wb.we     = dec_we;
      ex_d.wb.rd     = rd;
      ex_d.wb.wb_sel = dec_wb_sel;
      ex_d.is_br     = op_branch;
      ex_d.func3     = func3;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (ctl.imem_valid_i) begin
      ex_q  <= ex_d;
      mem_q <= ex_q.wb;
      wb_q  <= mem_q;
    end
  end

  assign ctl.stall_o        = stall;
  assign ctl.pip_jump_o     = jump;
  assign ctl.branch_taken_o = take;
  assign ctl.pc_next_sel_o  = pc_sel;
  assign ctl.rd_add_o       = wb_q.rd;
  assign ctl.wb_sel_o       = wb_q.wb_sel;
  assign ctl.reg_we_o       = wb_q.we & ctl.imem_valid_i;

endmodule

// File: tb/tb_rv32i_pipeline_hazard_ctrl.sv
// Bench for rv32i_pipeline_hazard_ctrl: instruction-history model plus
// directed programs with hand-counted stall/jump/branch expectations.
module tb_rv32i_pipeline_hazard_ctrl;
  import RV32i_pkg::*;

  typedef struct packed {
    logic [31:0] w;
    logic        z;
    logic        lt;
  } ent_t;

  localparam ent_t NOP = '{w: 32'h0000_0013, z: 1'b0, lt: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rv32i_pipeline_hazard_ctrl_if bus();

  rv32i_pipeline_hazard_ctrl dut (
    .clk_i    (clk),
    .resetn_i (rst_n),
    .ctl      (bus)
  );

  ent_t cur = NOP;
  ent_t nxt = NOP;
  logic valid = 1'b1;
  logic z_in = 1'b0;
  logic lt_in = 1'b0;
  logic chk_en = 1'b0;

  assign bus.instruction_i = cur.w;
  assign bus.imem_valid_i  = valid;
  assign bus.alu_zero_i    = z_in;
  assign bus.alu_lt_i      = lt_in;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit f_writes(logic [31:0] w);
    return (w[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03})
           && (w[11:7] != 5'd0);
  endfunction

  function automatic bit f_use1(logic [31:0] w);
    return w[6:0] inside {7'h67, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63};
  endfunction

  function automatic bit f_use2(logic [31:0] w);
    return w[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [1:0] f_wbsel(logic [31:0] w);
    if (w[6:0] == 7'h03) return SEL_WB_MEM;
    if (w[6:0] inside {7'h6F, 7'h67}) return SEL_WB_PC_PLUS_4;
    return SEL_WB_ALU;
  endfunction

  // 01x are not branch encodings; bit2 picks lt vs zero, bit0 inverts
  function automatic bit f_take(ent_t e);
    logic [2:0] f3;
    bit base;
    if (e.w[6:0] != 7'h63) return 1'b0;
    f3 = e.w[14:12];
    if (f3[2:1] == 2'b01) return 1'b0;
    base = f3[2] ? e.lt : e.z;
    return base ^ f3[0];
  endfunction

  ent_t hist [3];
  logic       m_haz, m_take, m_stall, m_jump, m_we;
  logic [2:0] m_sel;
  logic [4:0] m_rd;
  logic [1:0] m_wbs;

  always_comb begin
    m_haz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (f_writes(hist[i].w)) begin
        if (f_use1(cur.w) && cur.w[19:15] == hist[i].w[11:7]) m_haz = 1'b1;
        if (f_use2(cur.w) && cur.w[24:20] == hist[i].w[11:7]) m_haz = 1'b1;
      end
    end
    m_take  = f_take(hist[0]);
    m_stall = !m_take && m_haz;
    m_jump  = !m_take && !m_haz && (cur.w[6:0] inside {7'h6F, 7'h67});
    if (m_take) m_sel = SEL_PC_BRANCH;
    else if (m_stall) m_sel = SEL_PC_PLUS_4;
    else if (cur.w[6:0] == 7'h6F) m_sel = SEL_PC_JAL;
    else if (cur.w[6:0] == 7'h67) m_sel = SEL_PC_JALR;
    else m_sel = SEL_PC_PLUS_4;
    m_we  = valid && f_writes(hist[2].w);
    m_rd  = hist[2].w[11:7];
    m_wbs = f_wbsel(hist[2].w);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] <= NOP;
      hist[1] <= NOP;
      hist[2] <= NOP;
    end else if (valid) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= (m_take || m_stall) ? NOP : cur;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("stall", {31'd0, bus.stall_o}, {31'd0, m_stall});
      chk("pip_jump", {31'd0, bus.pip_jump_o}, {31'd0, m_jump});
      chk("branch_taken", {31'd0, bus.branch_taken_o}, {31'd0, m_take});
      chk("pc_next_sel", {29'd0, bus.pc_next_sel_o}, {29'd0, m_sel});
      chk("reg_we", {31'd0, bus.reg_we_o}, {31'd0, m_we});
      if (m_we) begin
        chk("rd_add", {27'd0, bus.rd_add_o}, {27'd0, m_rd});
        chk("wb_sel", {30'd0, bus.wb_sel_o}, {30'd0, m_wbs});
      end
    end
  end

  function automatic logic [31:0] i_t(logic [6:0] op, logic [4:0] rd,
                                      logic [2:0] f3, logic [4:0] rs1,
                                      logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_t(logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] b_t(logic [2:0] f3, logic [4:0] rs1,
                                      logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'h63};
  endfunction

  function automatic ent_t e(logic [31:0] w, logic z = 1'b0, logic lt = 1'b0);
    return '{w: w, z: z, lt: lt};
  endfunction

  ent_t prog [$];
  int pc;
  int st_cnt, m_st_cnt, jp_cnt, tk_cnt, tk_st, we0, frz_we;
  logic [31:0] we_seen;
  bit saw_pc4;

  task automatic clr();
    st_cnt = 0; m_st_cnt = 0; jp_cnt = 0; tk_cnt = 0; tk_st = 0;
    we0 = 0; frz_we = 0; we_seen = '0; saw_pc4 = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
    chk({tag, "_jump"}, {31'd0, bus.pip_jump_o}, 32'd0);
    chk({tag, "_take"}, {31'd0, bus.branch_taken_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.reg_we_o}, 32'd0);
    chk({tag, "_rd"}, {27'd0, bus.rd_add_o}, 32'd0);
    chk({tag, "_wbsel"}, {30'd0, bus.wb_sel_o}, 32'd0);
    chk({tag, "_pcsel"}, {29'd0, bus.pc_next_sel_o}, 32'd0);
  endtask

  task automatic run(input int n, input int frz_at, input int rst_at);
    bit nv;
    pc = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      if (valid && bus.stall_o) st_cnt++;
      if (valid && m_stall) m_st_cnt++;
      if (valid && bus.pip_jump_o) jp_cnt++;
      if (valid && bus.branch_taken_o) begin
        tk_cnt++;
        if (bus.stall_o) tk_st++;
      end
      if (bus.reg_we_o) begin
        we_seen[bus.rd_add_o] = 1'b1;
        if (bus.rd_add_o == 5'd0) we0++;
        if (bus.rd_add_o == 5'd1 && bus.wb_sel_o == SEL_WB_PC_PLUS_4)
          saw_pc4 = 1'b1;
        if (!valid) frz_we++;
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        nxt = NOP;
        pc = prog.size();
      end else if (!valid || m_stall) begin
        nxt = cur;
      end else if (m_take || m_jump) begin
        nxt = NOP;
        if (pc < prog.size()) pc++;
      end else begin
        nxt = (pc < prog.size()) ? prog[pc] : NOP;
        if (pc < prog.size()) pc++;
      end
      nv = !((c + 1 >= frz_at) && (c + 1 < frz_at + 4));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cur   = nxt;
      valid = nv;
      z_in  = hist[0].z;
      lt_in = hist[0].lt;
    end
  endtask

  int tk_total;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // back-to-back RAW: addi x5,x0,7 ; add x6,x5,x5
    clr();
    prog = '{e(i_t(7'h13, 5'd5, 3'd0, 5'd0, 12'd7)), e(r_t(5'd6, 5'd5, 5'd5))};
    run(12, -10, -1);
    chk("raw_stalls", st_cnt, 3);
    chk("raw_model_stalls", m_st_cnt, 3);
    chk("raw_we_x5", {31'd0, we_seen[5]}, 1);

    // x0 writers and stores never write back, no false hazards
    clr();
    prog = '{e(i_t(7'h13, 5'd0, 3'd0, 5'd0, 12'd1)), e(r_t(5'd1, 5'd0, 5'd0)),
             e({7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'h23}),
             e(i_t(7'h03, 5'd7, 3'b010, 5'd5, 12'd0))};
    run(12, -10, -1);
    chk("filt_stalls", st_cnt, 0);
    chk("filt_we_x0", we0, 0);
    chk("filt_we_x1", {31'd0, we_seen[1]}, 1);
    chk("filt_we_x7", {31'd0, we_seen[7]}, 1);

    // all eight func3 codes against all four flag combinations
    tk_total = 0;
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 4; fl++) begin
        clr();
        prog = '{e(b_t(f[2:0], 5'd1, 5'd2), fl[0], fl[1]),
                 e(r_t(5'd3, 5'd1, 5'd2)), e(i_t(7'h13, 5'd4, 3'd0, 5'd0, 12'd1))};
        run(9, -10, -1);
        tk_total += tk_cnt;
      end
    end
    chk("branch_takes", tk_total, 12);

    // jal x1,+16 : one flushed fetch, link lands in WB three cycles later
    clr();
    prog = '{e(32'h0100_00EF), e(i_t(7'h13, 5'd11, 3'd0, 5'd0, 12'd1)),
             e(i_t(7'h13, 5'd12, 3'd0, 5'd0, 12'd2))};
    run(10, -10, -1);
    chk("jal_jumps", jp_cnt, 1);
    chk("jal_link_pc4", {31'd0, saw_pc4}, 1);
    chk("jal_killed_x11", {31'd0, we_seen[11]}, 0);
    chk("jal_kept_x12", {31'd0, we_seen[12]}, 1);

    // jalr x1,0(x5) behind its rs1 writer: stall first, then redirect
    clr();
    prog = '{e(i_t(7'h13, 5'd5, 3'd0, 5'd0, 12'd7)),
             e(i_t(7'h67, 5'd1, 3'd0, 5'd5, 12'd0)),
             e(i_t(7'h13, 5'd13, 3'd0, 5'd0, 12'd1))};
    run(14, -10, -1);
    chk("jalr_stalls", st_cnt, 3);
    chk("jalr_jumps", jp_cnt, 1);
    chk("jalr_killed_x13", {31'd0, we_seen[13]}, 0);

    // taken bne while DEC add waits on x9
    clr();
    prog = '{e(i_t(7'h13, 5'd9, 3'd0, 5'd0, 12'd1)),
             e(b_t(3'b001, 5'd0, 5'd0), 1'b0, 1'b0),
             e(r_t(5'd10, 5'd9, 5'd9)),
             e(i_t(7'h13, 5'd14, 3'd0, 5'd0, 12'd1))};
    run(12, -10, -1);
    chk("bovh_takes", tk_cnt, 1);
    chk("bovh_stall_in_take", tk_st, 0);
    chk("bovh_stalls", st_cnt, 0);
    chk("bovh_killed_x10", {31'd0, we_seen[10]}, 0);

    // freeze for 4 cycles in the middle of the RAW stall
    clr();
    prog = '{e(i_t(7'h13, 5'd5, 3'd0, 5'd0, 12'd7)), e(r_t(5'd6, 5'd5, 5'd5))};
    run(16, 3, -1);
    chk("frz_stalls", st_cnt, 3);
    chk("frz_model_stalls", m_st_cnt, 3);
    chk("frz_we", frz_we, 0);
    chk("frz_we_x6", {31'd0, we_seen[6]}, 1);

    // asynchronous reset in the middle of the stall
    clr();
    prog = '{e(i_t(7'h13, 5'd5, 3'd0, 5'd0, 12'd7)), e(r_t(5'd6, 5'd5, 5'd5))};
    run(10, -10, 3);
    chk("rst_we_x6", {31'd0, we_seen[6]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
